// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line timing and the
// bit-period helper used by both the TX and RX ends so they agree on timing.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DefaultClkFreq = 100_000_000;
    localparam int unsigned DefaultBaud    = 115_200;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to the idle level so a
// released reset never looks like an input transition.
module sync_2ff #(
    parameter int unsigned Width    = 1,
    parameter logic        ResetVal = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {Width{ResetVal}};
            sync_q <= {Width{ResetVal}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_single_frame_rx.sv
// 8N1 UART receiver: qualifies the start bit at half a bit period, samples each
// data bit and the stop bit at mid-bit, and strobes either valid or frame_err.
module uart_single_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DefaultClkFreq,
    parameter int unsigned BAUD     = DefaultBaud
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] HalfMax = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitMax  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic rx_s;
    logic rx_prev_q;

    uart_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    sync_2ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only a genuine high-to-low edge starts a frame; a held-low
                // break line stays here.
                if (rx_prev_q && !rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfMax) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_single_frame_rx.sv
// Directed bench for uart_single_frame_rx at 32 clocks per bit; a per-cycle
// compare process checks all outputs against an expected-event model.
module tb_uart_single_frame_rx;

    localparam int unsigned TbClkFreq = 100_000_000;
    localparam int unsigned TbBaud    = 3_125_000;
    localparam int Cpb = 32;                     // 100e6 / 3.125e6
    localparam int Lat = 9 * Cpb + Cpb / 2 + 3;  // 9.5 bits + 3 clocks = 307
    localparam int KValid = 0;
    localparam int KErr   = 1;
    localparam int KNone  = 2;

    typedef struct {
        int         t_start;
        int         t_end;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int last_v_cycle = 0;
    logic [7:0] last_v_data = '0;
    logic [7:0] model_data = '0;
    int   v_cycles[$];
    ev_t  evq[$];

    uart_single_frame_rx #(
        .CLK_FREQ (TbClkFreq),
        .BAUD     (TbBaud)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected-event model.
    always @(negedge clk) begin
        logic exp_busy, exp_valid, exp_err;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst) begin
            chk("rst_data", {24'd0, data}, 32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_ferr", {31'd0, frame_err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end else begin
            if (evq.size() > 0) begin
                if (cyc >= evq[0].t_start && cyc < evq[0].t_end) exp_busy = 1'b1;
                if (cyc == evq[0].t_end) begin
                    if (evq[0].kind == KValid) begin
                        exp_valid  = 1'b1;
                        model_data = evq[0].data;
                    end else if (evq[0].kind == KErr) begin
                        exp_err = 1'b1;
                    end
                    void'(evq.pop_front());
                end
            end
            if (valid === 1'b1) begin
                n_valid++;
                last_v_cycle = cyc;
                last_v_data  = data;
                v_cycles.push_back(cyc);
            end
            if (frame_err === 1'b1) n_ferr++;
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("valid", {31'd0, valid}, {31'd0, exp_valid});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
            chk("data", {24'd0, data}, {24'd0, model_data});
        end
    end

    // Drives the first nbits of {stop, b, start}, LSB first, one bit per Cpb clocks.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (Cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        int k;
        k = cyc;
        evq.push_back('{t_start: k + 3, t_end: k + Lat, kind: (stop ? KValid : KErr), data: b});
        drive_frame(b, stop, 10);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * Cpb) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Single frame 0x41
        k = cyc;
        send(8'h41, 1'b1);
        idle_bits(2);
        chk("lat_41", last_v_cycle - k, 32'd307);
        chk("data_41", {24'd0, last_v_data}, 32'h41);
        chk("nvalid_41", n_valid, 32'd1);

        // Back-to-back 0x55 then 0xAA, no idle bit
        send(8'h55, 1'b1);
        send(8'hAA, 1'b1);
        idle_bits(2);
        chk("nvalid_b2b", n_valid, 32'd3);
        chk("gap_b2b", v_cycles[2] - v_cycles[1], 32'd320);
        chk("data_aa", {24'd0, last_v_data}, 32'hAA);

        // Glitch shorter than half a bit, then 0x3C
        k = cyc;
        evq.push_back('{t_start: k + 3, t_end: k + 3 + Cpb / 2, kind: KNone, data: 8'h00});
        rx = 1'b0;
        repeat (Cpb / 2 - 6) @(posedge clk);
        #1;
        idle_bits(1);
        chk("glitch_nvalid", n_valid, 32'd3);
        send(8'h3C, 1'b1);
        idle_bits(2);
        chk("data_3c", {24'd0, last_v_data}, 32'h3C);

        // Framing error into a 3-bit break, then 0x12
        send(8'h7E, 1'b0);
        repeat (3 * Cpb) @(posedge clk);
        #1;
        idle_bits(2);
        chk("nferr_break", n_ferr, 32'd1);
        chk("nvalid_break", n_valid, 32'd4);
        chk("data_kept", {24'd0, data}, 32'h3C);
        send(8'h12, 1'b1);
        idle_bits(2);
        chk("data_12", {24'd0, last_v_data}, 32'h12);

        // Reset during data bit 4, then 0xC3
        k = cyc;
        evq.push_back('{t_start: k + 3, t_end: 32'h7fff_ffff, kind: KNone, data: 8'h00});
        drive_frame(8'h99, 1'b1, 5);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        evq.delete();
        model_data = 8'h00;
        #1;
        chk("midrst_data", {24'd0, data}, 32'h00);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b0;
        idle_bits(2);
        chk("midrst_nvalid", n_valid, 32'd5);
        send(8'hC3, 1'b1);
        idle_bits(2);
        chk("data_c3", {24'd0, last_v_data}, 32'hC3);
        chk("nvalid_end", n_valid, 32'd6);
        chk("nferr_end", n_ferr, 32'd1);
        chk("queue_drained", evq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_single_frame_rx.md
Name: uart_single_frame_rx

Overview:
Receives 8N1 UART frames on a serial input pin, such as the JA1 loopback from uart_single_frame_tx. Each frame is sampled at mid-bit and delivered as a byte with a one-cycle valid strobe. It is the consumer stage for the TX path and will later feed command or echo logic. Baud rate is fixed at elaboration time; there is no flow control.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 868 at defaults), clocks per bit; derived, not overridden.

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  reset; asynchronous and active-high.
rx  input  1  asynchronous serial line; idles high.
data  output  8  last correctly received byte; holds its value between frames.
valid  output  1  one-cycle strobe; data is new on this cycle.
frame_err  output  1  one-cycle strobe; stop bit was sampled low.
busy  output  1  high from start-bit qualification to frame end.

Behaviour:
- Reset (asynchronous, active-high):
  - data=0x00, valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
  - Synchronizer flops and the previous-sample flop reset to 1 (idle line).
- Input path:
  - rx passes through a 2-flop synchronizer, giving rx_s.
  - All decisions use rx_s, so line-to-sample latency is 2 cycles.
- Falling-edge detect: rx_s_prev=1 and rx_s=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge, go to START, clear the counter, set busy=1.
  - A low line without a preceding high does not start a frame.
- START:
  - Count to CLKS_PER_BIT/2-1 (433), then sample rx_s.
  - If 0, clear the counter and bit index and go to DATA.
  - If 1, treat it as a glitch: go to IDLE, busy=0, no strobe.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s into a shift register, LSB first.
  - After bit index 7 is sampled, go to STOP.
- STOP:
  - After CLKS_PER_BIT clocks, sample rx_s.
  - If 1: on the next cycle data=shift register, valid=1 for exactly one cycle, busy=0, go to IDLE.
  - If 0: frame_err=1 for one cycle, data unchanged, valid=0, busy=0, go to IDLE.
  - After a framing error, a new frame requires the line to return high, then fall again. A break condition produces exactly one frame_err.
- Latency: valid rises 1 clock after the stop-bit mid-sample, about 9.5 bit times plus 3 clocks after the start-bit falling edge on rx.
- valid and frame_err are never high in the same cycle.
- Back-to-back frames:
  - The FSM is in IDLE half a bit before the stop bit ends.
  - A start edge immediately after the stop bit is accepted, with zero idle bits required.
- Falling edges during START, DATA or STOP are ignored apart from normal sampling; there is no resync mid-frame.
- Counters:
  - Bit counter width is clog2(CLKS_PER_BIT); the bit index is 3 bits.
  - Counters never wrap within a state; they are cleared on every state transition.
- Reset mid-frame aborts immediately with no strobe. The next complete frame after reset release is received normally.

Decomposition:
- Shared package/header uart_pkg:
  - State encodings IDLE/START/DATA/STOP.
  - Default CLK_FREQ/BAUD constants.
  - A clks_per_bit function, shared with uart_single_frame_tx so both ends agree on timing.
- Sub-module sync_2ff: generic 2-flop synchronizer with reset value 1. It is reused for other asynchronous inputs such as buttons.

Test Plan:
- Drive rx with the 8N1 frame 0x41 at 868 clk/bit -> exactly one valid pulse, data=0x41, busy high ~9.5 bit times, frame_err never asserted.
- Drive back-to-back 0x55 then 0xAA with no idle gap -> two valid pulses ~10 bit times (8680 clks) apart, data 0x55 then 0xAA.
- Pull rx low for 200 clocks, then high -> no valid, no frame_err; busy returns to 0 at start-qualify time; the next 0x3C frame is received correctly.
- Send 0x7E with the stop bit held low, then hold rx low for 3 bit times -> one frame_err pulse, valid=0, data keeps its previous value; after rx returns high, a following 0x12 frame yields valid with data=0x12.
- Assert rst during DATA bit 4 of a frame -> data=0, busy=0, no strobe; after release, a fresh 0xC3 frame yields data=0xC3.
- Loopback: tx of uart_single_frame_tx drives rx while send pulses with 0x41, then 0x00, then 0xFF -> three valid pulses with matching data, no frame_err.
